// File: rtl/fetch_queue.sv
// fetch_queue: ready/valid IF->ID instruction queue with single-cycle flush.
// Define FETCH_QUEUE_BYPASS_EN for a zero-latency path through an empty queue.
module fetch_queue #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     if_valid,
    input  logic [31:0]              if_Instruction,
    input  logic [31:0]              if_PC_plus4,
    output logic                     if_ready,
    output logic                     id_valid,
    output logic [31:0]              id_Instruction,
    output logic [31:0]              id_PC_plus4,
    input  logic                     id_ready,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          push, pop, store, bypass;
    logic [63:0]   head;

    assign if_ready = (count < FULL) && !reset;
`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass   = (count == '0) && if_valid && !flush && !reset;
    assign id_valid = !flush && ((count != '0) || bypass);
`else
    assign bypass   = 1'b0;
    assign id_valid = count != '0;
`endif
    // a bypassed entry taken by ID the same cycle is never stored
    assign push  = if_valid && if_ready;
    assign pop   = id_valid && id_ready && !bypass;
    assign store = push && !(bypass && id_ready);

    assign head           = bypass ? {if_Instruction, if_PC_plus4} : mem[rd_ptr];
    assign id_Instruction = id_valid ? head[63:32] : '0;
    assign id_PC_plus4    = id_valid ? head[31:0] : '0;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(store);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(store) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (store && !reset && !flush)
            mem[wr_ptr] <= {if_Instruction, if_PC_plus4};
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus checked against a queue-based
// transaction model of the fetch queue.
module tb_fetch_queue;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset, flush, if_valid, id_ready;
    logic [31:0] if_Instruction, if_PC_plus4;
    logic        if_ready, id_valid;
    logic [31:0] id_Instruction, id_PC_plus4;
    logic [$clog2(DEPTH):0] count;

    int ntotal = 0;
    int npass  = 0;
    int nfail  = 0;
    logic [63:0] q[$];
    logic [31:0] consumed[$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .if_valid(if_valid), .if_Instruction(if_Instruction), .if_PC_plus4(if_PC_plus4),
        .if_ready(if_ready), .id_valid(id_valid), .id_Instruction(id_Instruction),
        .id_PC_plus4(id_PC_plus4), .id_ready(id_ready), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, advance both.
    task automatic cyc(input logic r, input logic f, input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic rdy);
        logic        byp, ev, er;
        logic [63:0] head;
        reset = r; flush = f; if_valid = v; if_Instruction = ins; if_PC_plus4 = pc; id_ready = rdy;
        #1;
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (q.size() == 0) && v && !f && !r;
        ev  = !f && (q.size() > 0 || byp);
`else
        ev  = q.size() > 0;
`endif
        er   = (q.size() < DEPTH) && !r;
        head = !ev ? 64'h0 : byp ? {ins, pc} : q[0];
        check("count", 64'(count), 64'(q.size()));
        check("if_ready", 64'(if_ready), 64'(er));
        check("id_valid", 64'(id_valid), 64'(ev));
        check("id_Instruction", 64'(id_Instruction), 64'(head[63:32]));
        check("id_PC_plus4", 64'(id_PC_plus4), 64'(head[31:0]));
        if (id_valid && rdy && !r && !f) consumed.push_back(id_PC_plus4);
        if (r || f) q.delete();
        else begin
            if (ev && rdy && !byp) void'(q.pop_front());
            if (v && er && !(byp && rdy)) q.push_back({ins, pc});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        if_Instruction = '0; if_PC_plus4 = '0;
        repeat (2) @(posedge clk);
        #1;
        cyc(0, 0, 0, 32'h0, 32'h0, 0);
        cyc(0, 0, 0, 32'h0, 32'h0, 1);
        // streaming with ID always ready
        cyc(0, 0, 1, 32'h20080001, 32'h4, 1);
        cyc(0, 0, 1, 32'h20090002, 32'h8, 1);
        cyc(0, 0, 0, 32'h0, 32'h0, 1);
        cyc(0, 0, 0, 32'h0, 32'h0, 1);
        // fill while stalled, third push refused, then drain in order
        cyc(0, 0, 1, 32'hAAAA0001, 32'h100, 0);
        cyc(0, 0, 1, 32'hBBBB0002, 32'h104, 0);
        cyc(0, 0, 1, 32'hCCCC0003, 32'h108, 0);
        check("full_count", 64'(count), 64'(DEPTH));
        cyc(0, 0, 0, 32'h0, 32'h0, 1);
        cyc(0, 0, 0, 32'h0, 32'h0, 1);
        cyc(0, 0, 0, 32'h0, 32'h0, 1);
        // wrap-around: 7 entries with staggered ID readiness
        consumed.delete();
        for (int i = 1; i <= 7; i++) begin
            while (!if_ready) cyc(0, 0, 0, 32'h0, 32'h0, 1);
            cyc(0, 0, 1, 32'h1000_0000 + 32'(i), 32'(4 * i), (i % 2) == 0);
        end
        repeat (4) cyc(0, 0, 0, 32'h0, 32'h0, 1);
        check("wrap_seen", 64'(consumed.size()), 64'd7);
        for (int i = 0; i < consumed.size() && i < 7; i++)
            check("wrap_order", 64'(consumed[i]), 64'(4 * (i + 1)));
        // flush a full queue with a simultaneous push and pop
        consumed.delete();
        cyc(0, 0, 1, 32'h11110001, 32'h200, 0);
        cyc(0, 0, 1, 32'h11110002, 32'h204, 0);
        cyc(0, 1, 1, 32'hDEAD0001, 32'h999, 1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_ready", 64'(if_ready), 64'd1);
        repeat (2) cyc(0, 0, 0, 32'h0, 32'h0, 1);
        check("flush_dropped", 64'(consumed.size()), 64'd0);
        // reset mid-operation with a simultaneous push
        cyc(0, 0, 1, 32'h22220001, 32'h300, 0);
        cyc(1, 0, 1, 32'h22220002, 32'h304, 0);
        cyc(1, 0, 1, 32'h22220003, 32'h308, 0);
        consumed.delete();
        cyc(0, 0, 1, 32'h33330001, 32'h400, 0);
        cyc(0, 0, 0, 32'h0, 32'h0, 1);
        check("reset_first", consumed.size() > 0 ? 64'(consumed[0]) : 64'hFFFF, 64'h400);
        // random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0, ($urandom % 4) != 0,
                $urandom, $urandom, ($urandom % 3) != 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
